// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the stopwatch core: mode encodings and BCD digit width.
package stopwatch_core_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_ADJ_MIN = 2'b01,
        MODE_ADJ_SEC = 2'b10,
        MODE_PAUSED  = 2'b11
    } mode_e;

endpackage

// File: rtl/stopwatch_core_bcd_mod60.sv
// Two-digit BCD counter that wraps to 00 after reaching MAX; carry_out flags the wrapping increment.
module bcd_mod60
    import stopwatch_core_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic               clk,
    input  logic               res,
    input  logic               inc,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] units,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX / 10);
    localparam logic [DIGIT_W-1:0] MAX_U = DIGIT_W'(MAX % 10);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] units_q, units_d;
    logic               at_max;

    assign at_max    = (tens_q == MAX_T) && (units_q == MAX_U);
    assign carry_out = inc && at_max;
    assign tens      = tens_q;
    assign units     = units_q;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (res) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc) begin
            if (at_max) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == DIGIT_W'(9)) begin
                units_d = '0;
                tens_d  = tens_q + DIGIT_W'(1);
            end else begin
                units_d = units_q + DIGIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        tens_q  <= tens_d;
        units_q <= units_d;
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: mode control with pause toggle, driving minute and second BCD counters.
module stopwatch_core
    import stopwatch_core_pkg::*;
#(
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned SEC_MAX = 59
) (
    input  logic               clk,
    input  logic               res,
    input  logic               one_tick,
    input  logic               two_tick,
    input  logic               sel,
    input  logic               adj,
    input  logic               pause_btn,
    output logic [1:0]         mode,
    output logic [DIGIT_W-1:0] min1,
    output logic [DIGIT_W-1:0] min0,
    output logic [DIGIT_W-1:0] sec1,
    output logic [DIGIT_W-1:0] sec0
);

    mode_e mode_q, mode_d;
    logic  pause_q, pause_d;
    logic  paused_q, paused_d;
    logic  sec_inc, min_inc, sec_carry, min_carry;

    // Mode uses the updated paused flag so a pause edge shows in mode one cycle later.
    always_comb begin
        pause_d  = pause_btn;
        paused_d = paused_q ^ (pause_btn & ~pause_q);
        if (adj) begin
            mode_d = sel ? MODE_ADJ_SEC : MODE_ADJ_MIN;
        end else if (paused_d) begin
            mode_d = MODE_PAUSED;
        end else begin
            mode_d = MODE_RUN;
        end
        if (res) begin
            pause_d  = 1'b0;
            paused_d = 1'b0;
            mode_d   = MODE_RUN;
        end
    end

    always_ff @(posedge clk) begin
        pause_q  <= pause_d;
        paused_q <= paused_d;
        mode_q   <= mode_d;
    end

    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        unique case (mode_q)
            MODE_RUN: begin
                sec_inc = one_tick;
                min_inc = sec_carry;
            end
            MODE_ADJ_MIN: min_inc = two_tick;
            MODE_ADJ_SEC: sec_inc = two_tick;
            MODE_PAUSED:  ;
        endcase
    end

    assign mode = mode_q;

    bcd_mod60 #(.MAX(SEC_MAX)) u_sec (
        .clk       (clk),
        .res       (res),
        .inc       (sec_inc),
        .tens      (sec1),
        .units     (sec0),
        .carry_out (sec_carry)
    );

    bcd_mod60 #(.MAX(MIN_MAX)) u_min (
        .clk       (clk),
        .res       (res),
        .inc       (min_inc),
        .tens      (min1),
        .units     (min0),
        .carry_out (min_carry)
    );

endmodule
